// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: default datapath width and opcode encodings.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_comb.sv
// Combinational operand-B select and operation decode producing the next ALU result.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_reg_data2,
    input  logic [WIDTH-1:0] i_imm_ext,
    input  logic             i_alu_src,
    input  logic [2:0]       i_alu_control,
    output logic [WIDTH-1:0] o_result_c
);

    logic [WIDTH-1:0] w_src_b;

    assign w_src_b = i_alu_src ? i_imm_ext : i_reg_data2;

    // SLT uses a native signed compare so it stays correct when a - b overflows.
    always_comb begin
        o_result_c = '0;
        case (i_alu_control)
            ALU_ADD: o_result_c = i_src_a + w_src_b;
            ALU_SUB: o_result_c = i_src_a - w_src_b;
            ALU_AND: o_result_c = i_src_a & w_src_b;
            ALU_OR:  o_result_c = i_src_a | w_src_b;
            ALU_SLT: o_result_c = ($signed(i_src_a) < $signed(w_src_b)) ? WIDTH'(1) : '0;
            default: o_result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: one-cycle registered result with a Zero flag derived from the register.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] RegData2,
    input  logic [WIDTH-1:0] ImmExt,
    input  logic             ALUSrc,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    logic [WIDTH-1:0] w_next_result;
    logic [WIDTH-1:0] r_result;

    alu_comb #(
        .WIDTH(WIDTH)
    ) u_alu_comb (
        .i_src_a       (SrcA),
        .i_reg_data2   (RegData2),
        .i_imm_ext     (ImmExt),
        .i_alu_src     (ALUSrc),
        .i_alu_control (ALUControl),
        .o_result_c    (w_next_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else begin
            r_result <= w_next_result;
        end
    end

    assign ALUResult = r_result;
    assign Zero      = (r_result == '0);

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the execute-stage ALU.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] SrcA;
    logic [31:0] RegData2;
    logic [31:0] ImmExt;
    logic        ALUSrc;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .SrcA       (SrcA),
        .RegData2   (RegData2),
        .ImmExt     (ImmExt),
        .ALUSrc     (ALUSrc),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_res(input string tag, input logic [31:0] exp);
        checks++;
        assert (ALUResult === exp) else begin
            errors++;
            $error("FAIL %s result observed=%h expected=%h", tag, ALUResult, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic exp);
        checks++;
        assert (Zero === exp) else begin
            errors++;
            $error("FAIL %s zero observed=%b expected=%b", tag, Zero, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm,
                         input logic src, input logic [2:0] ctl);
        SrcA       = a;
        RegData2   = r2;
        ImmExt     = imm;
        ALUSrc     = src;
        ALUControl = ctl;
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm,
                        input logic src, input logic [2:0] ctl);
        drive(a, r2, imm, src, ctl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 3'b000);
        #1;
        chk_res("reset", 32'd0);
        chk_zero("reset", 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;

        step(32'd10, 32'd5, 32'd100, 1'b0, 3'b000);
        chk_res("add_reg", 32'd15);
        chk_zero("add_reg", 1'b0);

        step(32'd20, 32'd999, 32'd7, 1'b1, 3'b000);
        chk_res("add_imm", 32'd27);
        chk_zero("add_imm", 1'b0);

        step(32'd15, 32'd15, 32'd3, 1'b0, 3'b001);
        chk_res("sub_zero", 32'd0);
        chk_zero("sub_zero", 1'b1);

        step(32'd3, 32'd5, 32'd0, 1'b0, 3'b001);
        chk_res("sub_wrap", 32'hFFFF_FFFE);

        step(32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 1'b0, 3'b010);
        chk_res("and", 32'h0F0F_0000);

        step(32'h0000_FFFF, 32'h0, 32'h00FF_00FF, 1'b1, 3'b011);
        chk_res("or", 32'h00FF_FFFF);
        chk_zero("or", 1'b0);

        step(32'd5, 32'd10, 32'd0, 1'b0, 3'b101);
        chk_res("slt_lt", 32'd1);
        chk_zero("slt_lt", 1'b0);

        step(32'd30, 32'd10, 32'd0, 1'b0, 3'b101);
        chk_res("slt_ge", 32'd0);
        chk_zero("slt_ge", 1'b1);

        step(32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 3'b101);
        chk_res("slt_neg1", 32'd1);

        step(32'h8000_0000, 32'd1, 32'd0, 1'b0, 3'b101);
        chk_res("slt_min", 32'd1);

        step(32'd1, 32'h8000_0000, 32'd0, 1'b0, 3'b101);
        chk_res("slt_min_rev", 32'd0);

        step(32'd10, 32'd20, 32'd0, 1'b0, 3'b111);
        chk_res("undef_111", 32'd0);
        chk_zero("undef_111", 1'b1);

        step(32'd10, 32'd20, 32'd0, 1'b0, 3'b100);
        chk_res("undef_100", 32'd0);

        step(32'd10, 32'd20, 32'd0, 1'b0, 3'b110);
        chk_res("undef_110", 32'd0);

        // Inputs changed mid-cycle must not reach the outputs before the next edge.
        step(32'd40, 32'd2, 32'd0, 1'b0, 3'b000);
        chk_res("hold_pre", 32'd42);
        drive(32'd1, 32'd1, 32'd0, 1'b0, 3'b001);
        #3;
        chk_res("hold_mid", 32'd42);
        chk_zero("hold_mid", 1'b0);
        @(posedge clk);
        #1;
        chk_res("hold_post", 32'd0);
        chk_zero("hold_post", 1'b1);

        step(32'd10, 32'd5, 32'd0, 1'b0, 3'b000);
        chk_res("pre_rst", 32'd15);
        #2;
        rst = 1'b1;
        #1;
        chk_res("async_rst", 32'd0);
        chk_zero("async_rst", 1'b1);
        @(posedge clk);
        #1;
        chk_res("rst_held", 32'd0);
        rst = 1'b0;

        step(32'd3, 32'd4, 32'd0, 1'b0, 3'b000);
        chk_res("post_rst", 32'd7);
        chk_zero("post_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the RISC-V-style datapath execute stage.
- Selects operand B from a register read value or a sign-extended immediate.
- Performs ADD/SUB/AND/OR/SLT according to a 3-bit control code.
- Registers the result and produces a Zero flag used by branch logic.

Parameters:
- WIDTH, 32, datapath width of operands and result. Only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- SrcA  input  32  operand A.
- RegData2  input  32  register-file operand, used as B when ALUSrc=0.
- ImmExt  input  32  extended immediate, used as B when ALUSrc=1.
- ALUSrc  input  1  operand-B select: 0 selects RegData2, 1 selects ImmExt.
- ALUControl  input  3  operation code.
- ALUResult  output  32  registered operation result.
- Zero  output  1  high when ALUResult == 0.

Behaviour:
- SrcB = ALUSrc ? ImmExt : RegData2. This mux is combinational.
- Operation encoding, selected by ALUControl:
  - 000 ADD: SrcA + SrcB, modulo 2^32.
  - 001 SUB: SrcA - SrcB, modulo 2^32.
  - 010 AND: bitwise SrcA & SrcB.
  - 011 OR: bitwise SrcA | SrcB.
  - 101 SLT: 32'd1 if signed(SrcA) < signed(SrcB), else 32'd0.
  - 100, 110, 111 are undefined and produce 32'd0.
- No overflow or carry outputs. Wrap-around is silent.
- SLT uses a true signed compare. It must be correct when SUB overflows, e.g. 0x80000000 < 0x00000001 gives 1.
- Latency is 1 cycle. The result computed from inputs sampled at a rising clk edge appears on ALUResult after that edge.
- ALUResult holds its value until the next edge.
- Zero is combinational from the registered ALUResult: Zero = (ALUResult == 0). It is therefore aligned with ALUResult.
- Reset: when rst is asserted, ALUResult goes to 0 immediately, independent of clk. Zero is consequently 1.
- ALUResult stays 0 while rst is high.
- On the first rising edge after rst deasserts, the current inputs are captured normally.
- Reset mid-operation discards the pending result. There is no recovery of the pre-reset value.
- Inputs changing between edges have no effect on outputs until the next edge.
- There is no enable: every edge captures a new result.

Decomposition:
- Shared package alu_pkg holds:
  - Localparam constants for the opcodes: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - The WIDTH default.
- One natural sub-module, alu_comb: purely combinational operand-B mux plus operation select, producing the next result.
- The top alu holds only the result register (async reset) and the Zero compare.

Test Plan:
- ADD, register operand: rst pulse, then SrcA=10, RegData2=5, ImmExt=100, ALUSrc=0, ALUControl=000, one clk edge -> ALUResult=15, Zero=0.
- ADD, immediate operand: SrcA=20, ImmExt=7, ALUSrc=1, ALUControl=000 -> 27, Zero=0.
- SUB to zero: SrcA=15, RegData2=15, ALUSrc=0, ALUControl=001 -> 0, Zero=1.
- Bitwise ops:
  - AND with SrcA=0xFFFF0000, RegData2=0x0F0F0F0F, ALUSrc=0, ALUControl=010 -> 0x0F0F0000.
  - OR with SrcA=0x0000FFFF, ImmExt=0x00FF00FF, ALUSrc=1, ALUControl=011 -> 0x00FFFFFF, Zero=0.
- SLT cases:
  - SrcA=5, B=10 -> 1, Zero=0.
  - SrcA=30, B=10 -> 0, Zero=1.
  - SrcA=0xFFFFFFFF, B=1 -> 1 (signed).
  - SrcA=0x80000000, B=1 -> 1 (signed).
- Undefined opcode, latency and reset:
  - ALUControl=111 with SrcA=10, RegData2=20 -> 0, Zero=1.
  - Change inputs between edges -> outputs do not change until the next edge.
  - Assert rst between edges while ALUResult is nonzero -> ALUResult=0 and Zero=1 immediately, without a clock edge.
